// File: rtl/flow_loss_detector.sv
// flow_loss_detector
//   Multi-channel "loser" detector for the spirometer game. Each channel counts
//   consecutive strobed flow samples that are at or below a runtime threshold and
//   raises a loss flag once LIMIT such samples arrive in a row. The first channel to
//   lose (and whether others lost on the same sample) is latched for the score logic.
//
// Ports
//   iClk         clock, rising edge
//   iReset_n     synchronous reset, active low (highest priority)
//   iCe          sample strobe; counters and flags advance only when high
//   iClear       synchronous clear of all state (new round), beats iCe
//   ivThreshold  flow <= threshold counts as "no flow"
//   ivFlujo      packed samples, channel k at [k*FLOW_W +: FLOW_W]
//   ovLose       per-channel registered loss flag
//   ovLosePulse  one-cycle pulse on the edge where ovLose[k] rises
//   oFirstValid  a first loser has been latched
//   ovFirstIdx   index of the first loser (lowest index on a same-sample tie)
//   oTie         two or more channels lost on the same sample as the first loser

module flow_loss_detector #(
  parameter int unsigned FLOW_W = 8,
  parameter int unsigned NCH    = 2,
  parameter int unsigned LIMIT  = 3,
  parameter int unsigned STICKY = 1,
  parameter int unsigned CNT_W  = $clog2(LIMIT + 1),
  parameter int unsigned IDX_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                  iClk,
  input  logic                  iReset_n,
  input  logic                  iCe,
  input  logic                  iClear,
  input  logic [FLOW_W-1:0]     ivThreshold,
  input  logic [NCH*FLOW_W-1:0] ivFlujo,
  output logic [NCH-1:0]        ovLose,
  output logic [NCH-1:0]        ovLosePulse,
  output logic                  oFirstValid,
  output logic [IDX_W-1:0]      ovFirstIdx,
  output logic                  oTie
);

  localparam logic [CNT_W-1:0] LimitCnt = CNT_W'(LIMIT);
  localparam logic             Sticky   = (STICKY != 0);

  // State
  logic [NCH-1:0][CNT_W-1:0] cnt_q;
  logic [NCH-1:0]            lose_q;
  logic [NCH-1:0]            pulse_q;
  logic                      first_valid_q;
  logic [IDX_W-1:0]          first_idx_q;
  logic                      tie_q;

  // Values the state would take on a strobe edge
  logic [NCH-1:0][CNT_W-1:0] cnt_nxt;
  logic [NCH-1:0]            lose_nxt;
  logic [NCH-1:0]            low;
  logic [NCH-1:0]            rise;
  logic [IDX_W-1:0]          rise_idx;
  logic                      rise_tie;
  logic                      rise_found;

  // Per-channel counter and flag update
  always_comb begin
    cnt_nxt  = cnt_q;
    lose_nxt = lose_q;
    low      = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      low[k] = (ivFlujo[k*FLOW_W +: FLOW_W] <= ivThreshold);
      if (low[k]) begin
        // Saturate at LIMIT so a long run of low samples never wraps the counter
        cnt_nxt[k] = (cnt_q[k] == LimitCnt) ? LimitCnt : cnt_q[k] + 1'b1;
      end else if (Sticky && lose_q[k]) begin
        // A latched loser keeps its full count so the flag stays coherent with it
        cnt_nxt[k] = LimitCnt;
      end else begin
        cnt_nxt[k] = '0;
      end
      lose_nxt[k] = (cnt_nxt[k] == LimitCnt) || (Sticky && lose_q[k]);
    end
  end

  assign rise = lose_nxt & ~lose_q;

  // Lowest rising index and multi-rise detection for the first-loser latch
  always_comb begin
    rise_idx   = '0;
    rise_found = 1'b0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (rise[k] && !rise_found) begin
        rise_idx   = IDX_W'(k);
        rise_found = 1'b1;
      end
    end
    // Clearing the lowest set bit leaves something only if two or more bits rose
    rise_tie = ((rise & (rise - NCH'(1))) != '0);
  end

  always_ff @(posedge iClk) begin
    if (!iReset_n || iClear) begin
      cnt_q         <= '0;
      lose_q        <= '0;
      pulse_q       <= '0;
      first_valid_q <= 1'b0;
      first_idx_q   <= '0;
      tie_q         <= 1'b0;
    end else if (iCe) begin
      cnt_q   <= cnt_nxt;
      lose_q  <= lose_nxt;
      pulse_q <= rise;
      if (!first_valid_q && (rise != '0)) begin
        first_valid_q <= 1'b1;
        first_idx_q   <= rise_idx;
        tie_q         <= rise_tie;
      end
    end else begin
      pulse_q <= '0;
    end
  end

  assign ovLose      = lose_q;
  assign ovLosePulse = pulse_q;
  assign oFirstValid = first_valid_q;
  assign ovFirstIdx  = first_idx_q;
  assign oTie        = tie_q;

endmodule

// File: tb/tb_flow_loss_detector.sv
// tb_flow_loss_detector
//   Directed scoreboard bench. Two instances share the inputs: one with STICKY=1 and
//   one with STICKY=0 (both NCH=2, LIMIT=3). Each step drives one cycle of inputs and
//   queues the hand-computed outputs expected after that edge; a monitor process pops
//   and compares them just after every rising edge.

module tb_flow_loss_detector;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ce;
  logic       clr;
  logic [7:0] thr;
  logic [15:0] flujo;

  logic [1:0] lose_s, pulse_s, lose_n, pulse_n;
  logic       fv_s, fv_n, tie_s, tie_n;
  logic       idx_s, idx_n;

  always #5 clk = ~clk;

  flow_loss_detector #(.FLOW_W(8), .NCH(2), .LIMIT(3), .STICKY(1)) dut_sticky (
    .iClk        (clk),
    .iReset_n    (rst_n),
    .iCe         (ce),
    .iClear      (clr),
    .ivThreshold (thr),
    .ivFlujo     (flujo),
    .ovLose      (lose_s),
    .ovLosePulse (pulse_s),
    .oFirstValid (fv_s),
    .ovFirstIdx  (idx_s),
    .oTie        (tie_s)
  );

  flow_loss_detector #(.FLOW_W(8), .NCH(2), .LIMIT(3), .STICKY(0)) dut_plain (
    .iClk        (clk),
    .iReset_n    (rst_n),
    .iCe         (ce),
    .iClear      (clr),
    .ivThreshold (thr),
    .ivFlujo     (flujo),
    .ovLose      (lose_n),
    .ovLosePulse (pulse_n),
    .oFirstValid (fv_n),
    .ovFirstIdx  (idx_n),
    .oTie        (tie_n)
  );

  typedef struct packed {
    logic [1:0] l;
    logic [1:0] p;
    logic       fv;
    logic       idx;
    logic       tie;
    logic [1:0] l0;
    logic [1:0] p0;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   step_no = 0;
  logic [7:0] cur_thr = 8'd0;

  task automatic chk(input string name, input int act, input int req, input int n);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s step %0d: got %0d expected %0d", name, n, act, req);
    end
  endtask

  // Monitor: compare both instances against the queued expectation for this edge
  initial begin
    int n = 0;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        n++;
        chk("lose_sticky",  int'(lose_s),  int'(e.l),   n);
        chk("pulse_sticky", int'(pulse_s), int'(e.p),   n);
        chk("fv_sticky",    int'(fv_s),    int'(e.fv),  n);
        chk("idx_sticky",   int'(idx_s),   int'(e.idx), n);
        chk("tie_sticky",   int'(tie_s),   int'(e.tie), n);
        chk("lose_plain",   int'(lose_n),  int'(e.l0),  n);
        chk("pulse_plain",  int'(pulse_n), int'(e.p0),  n);
        chk("fv_plain",     int'(fv_n),    int'(e.fv),  n);
        chk("idx_plain",    int'(idx_n),   int'(e.idx), n);
        chk("tie_plain",    int'(tie_n),   int'(e.tie), n);
      end
    end
  end

  task automatic step(input logic rn, input logic c, input logic cl, input logic [7:0] t,
                      input logic [7:0] f0, input logic [7:0] f1,
                      input logic [1:0] l, input logic [1:0] p,
                      input logic fv, input logic idx, input logic tie,
                      input logic [1:0] l0, input logic [1:0] p0);
    exp_t e;
    @(negedge clk);
    rst_n = rn;
    ce    = c;
    clr   = cl;
    thr   = t;
    flujo = {f1, f0};
    e.l = l; e.p = p; e.fv = fv; e.idx = idx; e.tie = tie; e.l0 = l0; e.p0 = p0;
    exp_q.push_back(e);
    step_no++;
    @(posedge clk);
  endtask

  // Normal step where both instances are expected to agree
  task automatic st(input logic c, input logic [7:0] f0, input logic [7:0] f1,
                    input logic [1:0] l, input logic [1:0] p,
                    input logic fv, input logic idx, input logic tie);
    step(1'b1, c, 1'b0, cur_thr, f0, f1, l, p, fv, idx, tie, l, p);
  endtask

  // Clear with the strobe high and low flow on both channels: clear must still win
  task automatic do_clear();
    step(1'b1, 1'b1, 1'b1, cur_thr, 8'd0, 8'd0, 2'b00, 2'b00, 0, 0, 0, 2'b00, 2'b00);
  endtask

  initial begin
    rst_n = 1'b0; ce = 1'b0; clr = 1'b0; thr = '0; flujo = '0;

    // Reset with strobe and low flow active
    step(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 2'b00, 2'b00, 0, 0, 0, 2'b00, 2'b00);
    step(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 2'b00, 2'b00, 0, 0, 0, 2'b00, 2'b00);

    // T1: ch0 zero on three strobes
    cur_thr = 8'd0;
    st(1, 8'd0, 8'd9, 2'b00, 2'b00, 0, 0, 0);
    st(1, 8'd0, 8'd9, 2'b00, 2'b00, 0, 0, 0);
    st(1, 8'd0, 8'd9, 2'b01, 2'b01, 1, 0, 0);
    st(0, 8'd0, 8'd9, 2'b01, 2'b00, 1, 0, 0);   // pulse gone, strobe idle
    st(1, 8'd0, 8'd9, 2'b01, 2'b00, 1, 0, 0);   // saturated, no re-pulse

    // T4: flow returns; sticky holds, plain drops and can re-pulse
    step(1, 1, 0, cur_thr, 8'd20, 8'd9, 2'b01, 2'b00, 1, 0, 0, 2'b00, 2'b00);
    step(1, 1, 0, cur_thr, 8'd0,  8'd9, 2'b01, 2'b00, 1, 0, 0, 2'b00, 2'b00);
    step(1, 1, 0, cur_thr, 8'd0,  8'd9, 2'b01, 2'b00, 1, 0, 0, 2'b00, 2'b00);
    step(1, 1, 0, cur_thr, 8'd0,  8'd9, 2'b01, 2'b00, 1, 0, 0, 2'b01, 2'b01);
    do_clear();

    // T2: 0,0,5 breaks the run; three more zeros assert
    st(1, 8'd0, 8'd9, 2'b00, 2'b00, 0, 0, 0);
    st(1, 8'd0, 8'd9, 2'b00, 2'b00, 0, 0, 0);
    st(1, 8'd5, 8'd9, 2'b00, 2'b00, 0, 0, 0);
    st(1, 8'd0, 8'd9, 2'b00, 2'b00, 0, 0, 0);
    st(1, 8'd0, 8'd9, 2'b00, 2'b00, 0, 0, 0);
    st(1, 8'd0, 8'd9, 2'b01, 2'b01, 1, 0, 0);
    do_clear();

    // ch1 loses first, ch0 later: latch keeps index 1 and no tie
    st(1, 8'd9, 8'd0, 2'b00, 2'b00, 0, 0, 0);
    st(1, 8'd9, 8'd0, 2'b00, 2'b00, 0, 0, 0);
    st(1, 8'd9, 8'd0, 2'b10, 2'b10, 1, 1, 0);
    st(1, 8'd0, 8'd0, 2'b10, 2'b00, 1, 1, 0);
    st(1, 8'd0, 8'd0, 2'b10, 2'b00, 1, 1, 0);
    st(1, 8'd0, 8'd0, 2'b11, 2'b01, 1, 1, 0);
    do_clear();

    // T3: thr=10, ch0 exactly at threshold, ch1 below; both lose together
    cur_thr = 8'd10;
    st(1, 8'd10, 8'd7, 2'b00, 2'b00, 0, 0, 0);
    st(1, 8'd10, 8'd7, 2'b00, 2'b00, 0, 0, 0);
    st(1, 8'd10, 8'd7, 2'b11, 2'b11, 1, 0, 1);
    do_clear();

    // One above threshold never counts
    st(1, 8'd11, 8'd11, 2'b00, 2'b00, 0, 0, 0);
    st(1, 8'd11, 8'd11, 2'b00, 2'b00, 0, 0, 0);
    st(1, 8'd11, 8'd11, 2'b00, 2'b00, 0, 0, 0);
    st(1, 8'd11, 8'd11, 2'b00, 2'b00, 0, 0, 0);

    // T5: long strobe gaps with low flow held on the input
    cur_thr = 8'd0;
    st(1, 8'd0, 8'd9, 2'b00, 2'b00, 0, 0, 0);
    for (int i = 0; i < 50; i++) st(0, 8'd0, 8'd9, 2'b00, 2'b00, 0, 0, 0);
    st(1, 8'd0, 8'd9, 2'b00, 2'b00, 0, 0, 0);
    for (int i = 0; i < 50; i++) st(0, 8'd0, 8'd9, 2'b00, 2'b00, 0, 0, 0);
    st(1, 8'd0, 8'd9, 2'b01, 2'b01, 1, 0, 0);
    do_clear();

    // T6a: reset at cnt=2 with strobe high, then count restarts from zero
    st(1, 8'd0, 8'd9, 2'b00, 2'b00, 0, 0, 0);
    st(1, 8'd0, 8'd9, 2'b00, 2'b00, 0, 0, 0);
    step(1'b0, 1'b1, 1'b0, cur_thr, 8'd0, 8'd9, 2'b00, 2'b00, 0, 0, 0, 2'b00, 2'b00);
    st(1, 8'd0, 8'd9, 2'b00, 2'b00, 0, 0, 0);
    st(1, 8'd0, 8'd9, 2'b00, 2'b00, 0, 0, 0);
    st(1, 8'd0, 8'd9, 2'b01, 2'b01, 1, 0, 0);

    // T6b: clear at cnt=2 on ch1
    do_clear();
    st(1, 8'd9, 8'd0, 2'b00, 2'b00, 0, 0, 0);
    st(1, 8'd9, 8'd0, 2'b00, 2'b00, 0, 0, 0);
    do_clear();
    st(1, 8'd9, 8'd0, 2'b00, 2'b00, 0, 0, 0);
    st(1, 8'd9, 8'd0, 2'b00, 2'b00, 0, 0, 0);
    st(1, 8'd9, 8'd0, 2'b10, 2'b10, 1, 1, 0);

    repeat (3) @(posedge clk);
    #2;
    chk("queue_drained", exp_q.size(), 0, step_no);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
